// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the LC-3 memory access sequencer.
package mem_ctrl_pkg;

    localparam int          DATA_W          = 16;
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Runs one asynchronous-SRAM or memory-mapped I/O transfer per request with a
// fixed number of wait states, then pulses R for the control FSM.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT,
    parameter int          SRAM_AW     = 20
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                MEM_Req,
    input  logic                MEM_WE,
    input  logic [DATA_W-1:0]   MAR,
    input  logic [DATA_W-1:0]   MDR,
    input  logic [DATA_W-1:0]   Switches,
    input  logic [DATA_W-1:0]   SRAM_Data_In,
    output logic [SRAM_AW-1:0]  SRAM_Addr,
    output logic [DATA_W-1:0]   SRAM_Data_Out,
    output logic                SRAM_Data_OE,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic [DATA_W-1:0]   Data_to_CPU,
    output logic                R,
    output logic                Busy,
    output logic [DATA_W-1:0]   HEX_Data
);

    localparam int          CW       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_STATES - 1);

    generate
        if (WAIT_STATES < 1) begin : g_bad_wait_states
            $error("mem_access_ctrl: WAIT_STATES must be at least 1");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_cnt;
    logic                r_we;
    logic                r_is_io;
    logic [SRAM_AW-1:0]  r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_hex;
    logic                w_last;
    logic                w_capture;
    logic                w_sram_rd;
    logic                w_sram_wr;

    assign w_last    = (r_cnt == LAST_CNT);
    assign w_capture = (r_state == ACCESS) && w_last;
    assign w_sram_rd = !r_is_io && !r_we;
    assign w_sram_wr = !r_is_io &&  r_we;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Strobes decode straight from registered state so reset releases the bus at once.
    always_comb begin
        w_state_next = r_state;
        SRAM_CE_N    = 1'b1;
        SRAM_OE_N    = 1'b1;
        SRAM_WE_N    = 1'b1;
        SRAM_Data_OE = 1'b0;
        R            = 1'b0;
        Busy         = 1'b1;
        case (r_state)
            IDLE: begin
                Busy = 1'b0;
                if (MEM_Req) begin
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                w_state_next = ACCESS;
                SRAM_CE_N    = r_is_io;
                SRAM_OE_N    = !w_sram_rd;
                SRAM_Data_OE = w_sram_wr;
            end
            ACCESS: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
                SRAM_CE_N    = r_is_io;
                SRAM_OE_N    = !w_sram_rd;
                SRAM_WE_N    = !w_sram_wr;
                SRAM_Data_OE = w_sram_wr;
            end
            DONE: begin
                w_state_next = IDLE;
                SRAM_CE_N    = r_is_io;
                SRAM_Data_OE = w_sram_wr;
                R            = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign SRAM_UB_N = SRAM_CE_N;
    assign SRAM_LB_N = SRAM_CE_N;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if ((r_state == ACCESS) && !w_last) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_we    <= 1'b0;
            r_is_io <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && MEM_Req) begin
            r_we    <= MEM_WE;
            r_is_io <= (MAR == IO_ADDR);
            r_addr  <= SRAM_AW'(MAR);
            r_wdata <= MDR;
        end
    end

    // Read data lands on the edge that ends the last ACCESS cycle, so it is valid alongside R.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rdata <= '0;
            r_hex   <= '0;
        end else if (w_capture) begin
            if (!r_we) begin
                r_rdata <= r_is_io ? Switches : SRAM_Data_In;
            end else if (r_is_io) begin
                r_hex <= r_wdata;
            end
        end
    end

    assign SRAM_Addr     = r_addr;
    assign SRAM_Data_Out = r_wdata;
    assign Data_to_CPU   = r_rdata;
    assign HEX_Data      = r_hex;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side access sequencer for the LC-3 datapath: takes read/write requests from the control FSM and runs the external asynchronous SRAM bus with a fixed number of wait states.
- Returns read data on Data_to_CPU, which the MDR loads when MIO_EN is high.
- Decodes one memory-mapped I/O address: reads return the switches, writes update the hex-display register.
- Raises a one-cycle ready pulse (R) that the control FSM waits on.

Parameters:
- WAIT_STATES, 2, number of ACCESS cycles per transfer; legal range >= 1; 0 fails an elaboration assertion.
- IO_ADDR, 16'hFFFF, MAR value decoded as I/O instead of SRAM.
- SRAM_AW, 20, SRAM address width; upper SRAM_AW-16 bits are driven 0.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- MEM_Req  in  1  access request; sampled only in IDLE.
- MEM_WE  in  1  1 = write, 0 = read; sampled with MEM_Req.
- MAR  in  16  access address; sampled with MEM_Req.
- MDR  in  16  write data; sampled with MEM_Req.
- Switches  in  16  I/O read source.
- SRAM_Data_In  in  16  data from the SRAM pad.
- SRAM_Addr  out  SRAM_AW  registered SRAM address.
- SRAM_Data_Out  out  16  write data to the pad.
- SRAM_Data_OE  out  1  pad output enable for writes.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.
- Data_to_CPU  out  16  last read result; MDR source.
- R  out  1  access complete; high for exactly one cycle.
- Busy  out  1  high in every state except IDLE.
- HEX_Data  out  16  I/O write register.

Behaviour:
- Reset (asynchronous, Reset_n = 0), effective immediately including mid-access:
  - state IDLE, counter 0;
  - all *_N strobes 1, SRAM_Data_OE 0;
  - SRAM_Addr, SRAM_Data_Out, Data_to_CPU and HEX_Data all 0;
  - R 0, Busy 0.
- States: IDLE -> SETUP -> ACCESS (WAIT_STATES cycles) -> DONE -> IDLE.
- IDLE:
  - On MEM_Req = 1, latch MAR, MEM_WE and MDR, and compute is_io = (MAR == IDLE-latched IO_ADDR match).
  - Then go to SETUP.
  - On MEM_Req = 0, stay in IDLE.
- Latency, taking the request in cycle 0:
  - SETUP is cycle 1;
  - ACCESS is cycles 2 .. WAIT_STATES+1;
  - DONE is cycle WAIT_STATES+2, with R = 1;
  - IDLE is the next cycle, and a new request can be sampled there.
  - With MEM_Req held high, the block runs back-to-back accesses, one every WAIT_STATES+3 cycles.
- SRAM read (is_io = 0, we = 0):
  - CE_N, UB_N and LB_N are 0 from SETUP through DONE.
  - OE_N is 0 in SETUP and ACCESS, and 1 in DONE.
  - SRAM_Data_In is captured into Data_to_CPU at the edge that ends the last ACCESS cycle, so it is valid while R = 1.
- SRAM write (is_io = 0, we = 1):
  - CE_N, UB_N and LB_N are 0 from SETUP through DONE.
  - WE_N is 0 only during ACCESS, which gives address and data one cycle of setup and one of hold.
  - SRAM_Data_OE is 1 from SETUP through DONE.
  - OE_N stays 1.
  - Data_to_CPU is unchanged.
- I/O access (is_io = 1):
  - Same state sequence and latency as an SRAM access; CE_N, OE_N and WE_N stay 1 throughout.
  - Read: Switches are captured into Data_to_CPU at the same edge an SRAM read would capture.
  - Write: the latched MDR value is loaded into HEX_Data at the edge entering DONE.
- SRAM_Addr = {zeros, latched MAR}. It is updated on leaving IDLE and held until the next request.
- Data_to_CPU and HEX_Data hold their values between accesses.
- MEM_Req, MEM_WE, MAR and MDR are ignored outside IDLE. Changes during an access have no effect.
- Busy = 1 in SETUP, ACCESS and DONE.
- R is never high outside DONE.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, DONE);
  - the IO_ADDR default constant;
  - the data-width constant, 16.
- Wait counter: $clog2(WAIT_STATES+1) bits, kept inline.
- No sub-module; the FSM and the output registers stay in one module.

Test Plan:
- Reset: drive Reset_n low mid-ACCESS of a write.
  - Strobes go to 1 and SRAM_Data_OE to 0 within the same cycle, with no clock edge.
  - Data_to_CPU, HEX_Data and R read 0.
  - After release, the FSM sits in IDLE.
- SRAM read, WAIT_STATES = 2, MAR = 16'h3000, SRAM model returns 16'hBEEF:
  - SRAM_Addr = 20'h03000;
  - OE_N low in cycles 1–3;
  - R high in cycle 4 only;
  - Data_to_CPU = 16'hBEEF from cycle 4 onward.
- SRAM write, MAR = 16'h0040, MDR = 16'h1234:
  - WE_N low in cycles 2–3 only;
  - SRAM_Data_Out = 16'h1234 with SRAM_Data_OE high in cycles 1–4;
  - a read-back of 16'h0040 returns 16'h1234.
- I/O read, MAR = 16'hFFFF, Switches = 16'h00A5:
  - CE_N never goes low;
  - R in cycle 4;
  - Data_to_CPU = 16'h00A5.
- I/O write, MAR = 16'hFFFF, MDR = 16'hCAFE:
  - HEX_Data = 16'hCAFE from cycle 4;
  - no SRAM strobe toggles;
  - Data_to_CPU is unchanged.
- MEM_Req held high for 10 cycles, with MAR changed mid-access:
  - the first access uses its original MAR;
  - R pulses in cycles 4 and 9;
  - the second access uses the MAR value present in cycle 5.
